// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg
// Shared definitions for the ID-stage register-hazard scoreboard:
//   - lat_class_e : producer latency classes decoded in ID
//   - Stop/NoStop : stall request encodings shared with the ctrl stall logic
//   - lat_fits    : range check used when elaborating countdown widths
package id_scoreboard_pkg;

  typedef enum logic [1:0] {
    LatAlu  = 2'b00,
    LatLoad = 2'b01,
    LatMul  = 2'b10,
    LatRsv  = 2'b11
  } lat_class_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // A latency must be representable in a cw-bit countdown without wrapping.
  function automatic bit lat_fits(input int lat, input int cw);
    return (lat >= 0) && (lat < (1 << cw));
  endfunction

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// sb_entry
// Countdown for one architectural register. A nonzero count means a
// writer is still in flight and the register's value is not yet
// forwardable.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   hold      : freeze the count (pipeline held downstream)
//   load      : start a new countdown at load_val (wins over decrement)
//   load_val  : latency of the newly issued writer
//   cnt       : current countdown value
//   busy      : cnt is nonzero
module sb_entry #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          busy
);

  // Load has priority so a writer issuing this cycle replaces whatever
  // remains of the previous writer's countdown. Zero counts saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard
// Per-register hazard scoreboard for the ID stage. Each tracked register
// holds a countdown of the cycles until its pending result can be
// forwarded; ID stalls while any read source or a same-destination
// write-after-write is still counting.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   stall_i          : ctrl is holding ID/EX this cycle
//   issue_valid_i    : ID holds a decoded instruction
//   rs1_read_i/addr  : source 1 use and address
//   rs2_read_i/addr  : source 2 use and address
//   wreg_i, wd_i     : destination write enable and address
//   lat_class_i      : producer class of this instruction
//   stallreq_o       : hazard stall request to ctrl
//   issue_fire_o     : instruction moves into EX this cycle
//   rs1_busy_o       : source 1 blocked by a pending writer
//   rs2_busy_o       : source 2 blocked by a pending writer
//   busy_count_o     : number of registers with a live countdown
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int CW       = 3,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          issue_valid_i,
  input  logic          rs1_read_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic          rs2_read_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic          wreg_i,
  input  logic [AW-1:0] wd_i,
  input  logic [1:0]    lat_class_i,
  output logic          stallreq_o,
  output logic          issue_fire_o,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o,
  output logic [AW:0]   busy_count_o
);

  localparam int NADDR = 2 ** AW;

  // Refuse to build a configuration whose counters could wrap or whose
  // address field cannot reach every register.
  if (!lat_fits(ALU_LAT, CW) || !lat_fits(LOAD_LAT, CW) || !lat_fits(MUL_LAT, CW)) begin : g_bad_lat
    $error("id_scoreboard: a latency does not fit in the CW-bit countdown");
  end
  if (NADDR < NREGS) begin : g_bad_aw
    $error("id_scoreboard: AW too narrow for NREGS");
  end

  function automatic logic [CW-1:0] lat_of(input logic [1:0] cls);
    case (lat_class_e'(cls))
      LatLoad: return CW'(LOAD_LAT);
      LatMul:  return CW'(MUL_LAT);
      default: return CW'(ALU_LAT);
    endcase
  endfunction

  // The lookup table spans the whole address space so any address can be
  // indexed; r0 and addresses beyond NREGS read as permanently idle.
  logic [CW-1:0]    cnt_tab [NADDR];
  logic [NREGS-1:0] busy_vec;
  logic [CW-1:0]    new_lat;
  logic             waw_hold;

  assign new_lat = lat_of(lat_class_i);

  for (genvar r = 0; r < NADDR; r++) begin : g_reg
    if ((r == 0) || (r >= NREGS)) begin : g_idle
      assign cnt_tab[r] = '0;
    end else begin : g_track
      sb_entry #(.CW(CW)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall_i),
        .load     (issue_fire_o && wreg_i && (wd_i == AW'(r)) && (new_lat != '0)),
        .load_val (new_lat),
        .cnt      (cnt_tab[r]),
        .busy     (busy_vec[r])
      );
    end
  end
  assign busy_vec[0] = 1'b0;

  // Busy checks use the pre-update counts, so an instruction that reads
  // its own destination never blocks on itself.
  assign rs1_busy_o = rs1_read_i && (rs1_addr_i != '0) && (cnt_tab[rs1_addr_i] != '0);
  assign rs2_busy_o = rs2_read_i && (rs2_addr_i != '0) && (cnt_tab[rs2_addr_i] != '0);

  // A younger writer must not finish before an older, slower writer to
  // the same register, otherwise the stale value would win.
  assign waw_hold = wreg_i && (wd_i != '0) && (cnt_tab[wd_i] > new_lat);

  assign stallreq_o   = (issue_valid_i && (rs1_busy_o || rs2_busy_o || waw_hold)) ? Stop : NoStop;
  assign issue_fire_o = issue_valid_i && (stallreq_o == NoStop) && !stall_i;

  // Population count of live countdowns.
  always_comb begin
    busy_count_o = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_count_o = busy_count_o + {{AW{1'b0}}, busy_vec[r]};
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard
// Directed bench for id_scoreboard with default parameters
// (ALU_LAT=0, LOAD_LAT=1, MUL_LAT=3). Inputs change just after the falling
// edge and outputs are sampled 1ns later. Each check compares the packed
// word {stallreq, fire, rs1_busy, rs2_busy} and busy_count.
module tb_id_scoreboard;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] MUL = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall_i = 1'b0;
  logic       issue_valid_i = 1'b0;
  logic       rs1_read_i = 1'b0;
  logic [4:0] rs1_addr_i = '0;
  logic       rs2_read_i = 1'b0;
  logic [4:0] rs2_addr_i = '0;
  logic       wreg_i = 1'b0;
  logic [4:0] wd_i = '0;
  logic [1:0] lat_class_i = '0;
  logic       stallreq_o;
  logic       issue_fire_o;
  logic       rs1_busy_o;
  logic       rs2_busy_o;
  logic [5:0] busy_count_o;

  int total = 0;
  int bad = 0;
  logic [9:0] exp;

  id_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .issue_valid_i(issue_valid_i),
    .rs1_read_i   (rs1_read_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_read_i   (rs2_read_i),
    .rs2_addr_i   (rs2_addr_i),
    .wreg_i       (wreg_i),
    .wd_i         (wd_i),
    .lat_class_i  (lat_class_i),
    .stallreq_o   (stallreq_o),
    .issue_fire_o (issue_fire_o),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_busy_o   (rs2_busy_o),
    .busy_count_o (busy_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {stallreq_o, issue_fire_o, rs1_busy_o, rs2_busy_o, busy_count_o};
  endfunction

  // Present one instruction for one cycle and let outputs settle.
  task automatic step(input logic v, input logic rd1, input logic [4:0] a1,
                      input logic rd2, input logic [4:0] a2, input logic wr,
                      input logic [4:0] wd, input logic [1:0] cls, input logic st);
    @(negedge clk);
    issue_valid_i = v;
    rs1_read_i    = rd1;
    rs1_addr_i    = a1;
    rs2_read_i    = rd2;
    rs2_addr_i    = a2;
    wreg_i        = wr;
    wd_i          = wd;
    lat_class_i   = cls;
    stall_i       = st;
    #1;
  endtask

  task automatic test_reset();
    #1;
    exp = {4'b0000, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL reset_idle got=%b want=%b", outs(), exp); end
    issue_valid_i = 1'b1; rs1_read_i = 1'b1; rs1_addr_i = 5'd1;
    #1;
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL reset_reader got=%b want=%b", outs(), exp); end
    @(negedge clk);
    rst = 1'b1;
    issue_valid_i = 1'b0; rs1_read_i = 1'b0; rs1_addr_i = '0;
  endtask

  task automatic test_load_use();
    step(1, 0, 0, 0, 0, 1, 3, LD, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL lu_c0 got=%b want=%b", outs(), exp); end
    step(1, 1, 3, 1, 1, 1, 4, ALU, 0);
    exp = {4'b1010, 6'd1}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL lu_c1 got=%b want=%b", outs(), exp); end
    step(1, 1, 3, 1, 1, 1, 4, ALU, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL lu_c2 got=%b want=%b", outs(), exp); end
  endtask

  task automatic test_mul_chain();
    logic [9:0] seq_a [5];
    logic [9:0] seq_b [6];
    logic [9:0] seq_c [5];
    // Plain chain: stall cycles 1..3, fire at 4.
    seq_a = '{{4'b0100, 6'd0}, {4'b1010, 6'd1}, {4'b1010, 6'd1}, {4'b1010, 6'd1}, {4'b0100, 6'd0}};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) step(1, 0, 0, 0, 0, 1, 5, MUL, 0);
      else        step(1, 1, 5, 0, 0, 1, 6, ALU, 0);
      exp = seq_a[c]; total++;
      if (outs() !== exp) begin bad++; $display("FAIL mul_c%0d got=%b want=%b", c, outs(), exp); end
    end
    // Same chain with ctrl hold on cycle 2: fire slips to cycle 5.
    seq_b = '{{4'b0100, 6'd0}, {4'b1010, 6'd1}, {4'b1010, 6'd1}, {4'b1010, 6'd1},
              {4'b1010, 6'd1}, {4'b0100, 6'd0}};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) step(1, 0, 0, 0, 0, 1, 5, MUL, 0);
      else        step(1, 1, 5, 0, 0, 1, 6, ALU, (c == 2));
      exp = seq_b[c]; total++;
      if (outs() !== exp) begin bad++; $display("FAIL mulstall_c%0d got=%b want=%b", c, outs(), exp); end
    end
    // Invalid slot still reports busy; both sources naming r5 both assert.
    seq_c = '{{4'b0100, 6'd0}, {4'b0010, 6'd1}, {4'b1011, 6'd1}, {4'b1011, 6'd1}, {4'b0100, 6'd0}};
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      step(1, 0, 0, 0, 0, 1, 5, MUL, 0);
      else if (c == 1) step(0, 1, 5, 0, 0, 0, 0, ALU, 0);
      else             step(1, 1, 5, 1, 5, 1, 6, ALU, 0);
      exp = seq_c[c]; total++;
      if (outs() !== exp) begin bad++; $display("FAIL mulsame_c%0d got=%b want=%b", c, outs(), exp); end
    end
    // Ctrl hold with no hazard: no stall request, no fire.
    step(1, 1, 1, 0, 0, 1, 6, ALU, 1);
    exp = {4'b0000, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL hold_nohaz got=%b want=%b", outs(), exp); end
  endtask

  task automatic test_waw();
    logic [9:0] seq_a [5];
    logic [9:0] seq_b [6];
    // ALU write behind a MUL to r7 waits until the count reaches 0.
    seq_a = '{{4'b0100, 6'd0}, {4'b1000, 6'd1}, {4'b1000, 6'd1}, {4'b1000, 6'd1}, {4'b0100, 6'd0}};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) step(1, 0, 0, 0, 0, 1, 7, MUL, 0);
      else        step(1, 1, 1, 1, 2, 1, 7, ALU, 0);
      exp = seq_a[c]; total++;
      if (outs() !== exp) begin bad++; $display("FAIL waw_c%0d got=%b want=%b", c, outs(), exp); end
    end
    // Load behind MUL fires once cnt=1 <= LOAD_LAT and reloads r7 to 1.
    seq_b = '{{4'b0100, 6'd0}, {4'b1000, 6'd1}, {4'b1000, 6'd1}, {4'b0100, 6'd1},
              {4'b1010, 6'd1}, {4'b0100, 6'd0}};
    for (int c = 0; c < 6; c++) begin
      if (c == 0)     step(1, 0, 0, 0, 0, 1, 7, MUL, 0);
      else if (c < 4) step(1, 0, 0, 0, 0, 1, 7, LD, 0);
      else            step(1, 1, 7, 0, 0, 1, 8, ALU, 0);
      exp = seq_b[c]; total++;
      if (outs() !== exp) begin bad++; $display("FAIL wawld_c%0d got=%b want=%b", c, outs(), exp); end
    end
  endtask

  task automatic test_r0_nonread();
    step(1, 0, 0, 0, 0, 1, 0, LD, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL r0_write got=%b want=%b", outs(), exp); end
    step(1, 1, 0, 1, 0, 1, 4, ALU, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL r0_read got=%b want=%b", outs(), exp); end
    step(1, 0, 0, 0, 0, 1, 3, LD, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL nr_load got=%b want=%b", outs(), exp); end
    step(1, 0, 3, 1, 1, 1, 4, ALU, 0);
    exp = {4'b0100, 6'd1}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL nr_noread got=%b want=%b", outs(), exp); end
    step(0, 0, 0, 0, 0, 0, 0, ALU, 0);
    exp = {4'b0000, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL nr_drain got=%b want=%b", outs(), exp); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 1, 0, 0, 1, 2, ALU, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL b2b_add got=%b want=%b", outs(), exp); end
    step(1, 1, 2, 1, 1, 1, 9, ALU, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL b2b_sub got=%b want=%b", outs(), exp); end
    // Load reading its own destination does not block on itself.
    step(1, 1, 3, 0, 0, 1, 3, LD, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL self_dest got=%b want=%b", outs(), exp); end
    step(1, 1, 3, 1, 3, 1, 3, ALU, 0);
    exp = {4'b1011, 6'd1}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL self_next got=%b want=%b", outs(), exp); end
    step(1, 1, 3, 1, 3, 1, 3, ALU, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL self_fire got=%b want=%b", outs(), exp); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 1, 5, MUL, 0);
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL rm_mul got=%b want=%b", outs(), exp); end
    step(1, 1, 5, 0, 0, 1, 6, ALU, 0);
    exp = {4'b1010, 6'd1}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL rm_before got=%b want=%b", outs(), exp); end
    #2 rst = 1'b0;
    #1;
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL rm_async got=%b want=%b", outs(), exp); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp = {4'b0100, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL rm_after got=%b want=%b", outs(), exp); end
    step(0, 0, 0, 0, 0, 0, 0, ALU, 0);
    exp = {4'b0000, 6'd0}; total++;
    if (outs() !== exp) begin bad++; $display("FAIL rm_idle got=%b want=%b", outs(), exp); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul_chain();
    test_waw();
    test_r0_nonread();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
